// File: rtl/atom_window_buffer.sv
// Atom window buffer: stores up to DEPTH atoms and streams WIN-atom sliding windows over them.
// Latency: first window valid one cycle after an accepted start; one window per cycle thereafter.
// Backpressure: win_* hold while win_valid && !win_ready; in_ready drops while streaming or when full.
// Optional feature: define ATOM_WINDOW_WRAP_EN for circular windows (N windows, lanes wrap past the end).
module atom_window_buffer #(
    parameter int COORD_W = 32,
    parameter int DEPTH   = 64,
    parameter int WIN     = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [COORD_W-1:0]   in_x,
    input  logic signed [COORD_W-1:0]   in_y,
    input  logic signed [COORD_W-1:0]   in_z,
    input  logic [4:0]                  in_res_id,
    input  logic [3:0]                  in_atom_idx,
    input  logic                        start,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [WIN*COORD_W-1:0]      win_x,
    output logic [WIN*COORD_W-1:0]      win_y,
    output logic [WIN*COORD_W-1:0]      win_z,
    output logic [WIN*5-1:0]            win_res_id,
    output logic [WIN*4-1:0]            win_atom_idx,
    output logic [AW-1:0]               win_base,
    output logic                        win_last,
    output logic [AW:0]                 count,
    output logic                        busy,
    output logic                        err
);

    localparam logic [AW:0] WIN_C   = (AW+1)'(WIN);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Atom storage; never reset, only slots below count are ever read.
    logic signed [COORD_W-1:0] r_mem_x [DEPTH];
    logic signed [COORD_W-1:0] r_mem_y [DEPTH];
    logic signed [COORD_W-1:0] r_mem_z [DEPTH];
    logic [4:0]                r_mem_res [DEPTH];
    logic [3:0]                r_mem_idx [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_len;
    logic [AW-1:0] r_base;

    logic                   r_win_vld;
    logic                   r_win_last;
    logic                   r_err;
    logic [WIN*COORD_W-1:0] r_win_x;
    logic [WIN*COORD_W-1:0] r_win_y;
    logic [WIN*COORD_W-1:0] r_win_z;
    logic [WIN*5-1:0]       r_win_res;
    logic [WIN*4-1:0]       r_win_idx;

    logic          w_load_acc;
    logic          w_hs;
    logic          w_win_load;
    logic          w_win_done;
    logic          w_start_acc;
    logic          w_start_err;
    logic [AW-1:0] w_nb;
    logic [AW:0]   w_n;
    logic          w_nb_last;
    logic [AW-1:0] w_slot [WIN];

    assign busy       = (r_state == S_STREAM);
    assign in_ready   = !busy && (r_count < DEPTH_C);
    assign w_load_acc = in_valid && in_ready && !clear;
    assign w_hs       = r_win_vld && win_ready;
    // Length of the window set: the live count when starting, the latched one mid-stream.
    assign w_n        = (r_state == S_IDLE) ? r_count : r_len;

    assign count        = r_count;
    assign win_valid    = r_win_vld;
    assign win_last     = r_win_last;
    assign win_base     = r_base;
    assign err          = r_err;
    assign win_x        = r_win_x;
    assign win_y        = r_win_y;
    assign win_z        = r_win_z;
    assign win_res_id   = r_win_res;
    assign win_atom_idx = r_win_idx;

    // Next-state and window-advance decisions; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_win_load  = 1'b0;
        w_win_done  = 1'b0;
        w_start_acc = 1'b0;
        w_start_err = 1'b0;
        w_nb        = r_base;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (r_count >= WIN_C) begin
                        w_state_nxt = S_STREAM;
                        w_win_load  = 1'b1;
                        w_start_acc = 1'b1;
                        w_nb        = '0;
                    end else begin
                        w_start_err = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                if (w_hs) begin
                    if (r_win_last) begin
                        w_state_nxt = S_IDLE;
                        w_win_done  = 1'b1;
                    end else begin
                        w_win_load = 1'b1;
                        w_nb       = r_base + AW'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_win_load  = 1'b0;
            w_win_done  = 1'b0;
            w_start_acc = 1'b0;
            w_start_err = 1'b0;
        end
    end

    // Slot addresses for each lane of the window about to be loaded, and its last flag.
    always_comb begin
        for (int k = 0; k < WIN; k++) begin
`ifdef ATOM_WINDOW_WRAP_EN
            w_slot[k] = w_nb + AW'(k)
                        - ((({1'b0, w_nb} + (AW+1)'(k)) >= w_n) ? w_n[AW-1:0] : '0);
`else
            w_slot[k] = w_nb + AW'(k);
`endif
        end
`ifdef ATOM_WINDOW_WRAP_EN
        w_nb_last = ({1'b0, w_nb} == (w_n - ONE_C));
`else
        w_nb_last = ({1'b0, w_nb} == (w_n - WIN_C));
`endif
    end

    // Control state: FSM, write pointer, count, latched length and window base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_len    <= '0;
            r_base   <= '0;
        end else if (clear) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_base   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_count  <= r_count + ONE_C;
            end
            if (w_start_acc) begin
                r_len <= r_count;
            end
            if (w_win_load) begin
                r_base <= w_nb;
            end
        end
    end

    // Atom write port.
    always_ff @(posedge clk) begin
        if (w_load_acc) begin
            r_mem_x[r_wr_ptr]   <= in_x;
            r_mem_y[r_wr_ptr]   <= in_y;
            r_mem_z[r_wr_ptr]   <= in_z;
            r_mem_res[r_wr_ptr] <= in_res_id;
            r_mem_idx[r_wr_ptr] <= in_atom_idx;
        end
    end

    // Registered window outputs: load a new window or drop valid after the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
            r_win_x    <= '0;
            r_win_y    <= '0;
            r_win_z    <= '0;
            r_win_res  <= '0;
            r_win_idx  <= '0;
        end else if (clear) begin
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
        end else if (w_win_load) begin
            r_win_vld  <= 1'b1;
            r_win_last <= w_nb_last;
            for (int k = 0; k < WIN; k++) begin
                r_win_x[k*COORD_W +: COORD_W] <= r_mem_x[w_slot[k]];
                r_win_y[k*COORD_W +: COORD_W] <= r_mem_y[w_slot[k]];
                r_win_z[k*COORD_W +: COORD_W] <= r_mem_z[w_slot[k]];
                r_win_res[k*5 +: 5]           <= r_mem_res[w_slot[k]];
                r_win_idx[k*4 +: 4]           <= r_mem_idx[w_slot[k]];
            end
        end else if (w_win_done) begin
            r_win_vld  <= 1'b0;
            r_win_last <= 1'b0;
        end
    end

    // One-cycle pulse for a start refused because too few atoms are stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_start_err;
        end
    end

endmodule
